// File: rtl/steer_merge_pkg.sv
// rtl/steer_merge_pkg.sv - shared token layout, path encoding and token helpers
package steer_merge_pkg;

    localparam int GO_LENGTH = 8;

    typedef enum logic {
        PATH_LEFT  = 1'b0,
        PATH_RIGHT = 1'b1
    } path_e;

    // A token carries its valid flag in the top bit, payload below it.
    function automatic logic tok_valid(input logic [GO_LENGTH:0] tok);
        return tok[GO_LENGTH];
    endfunction

    function automatic logic [GO_LENGTH-1:0] tok_payload(input logic [GO_LENGTH:0] tok);
        return tok[GO_LENGTH-1:0];
    endfunction

endpackage

// File: rtl/elastic_buf2.sv
// rtl/elastic_buf2.sv - two-entry elastic FIFO with registered full flag
module elastic_buf2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enq,
    input  logic [W-1:0] enq_data,
    input  logic         deq,
    output logic         full,
    output logic         head_valid,
    output logic [W-1:0] head_data
);

    logic [W-1:0] mem [2];
    logic         head;
    logic         tail;
    logic [1:0]   count;
    logic         do_enq;
    logic         do_deq;

    assign full       = (count == 2'd2);
    assign head_valid = (count != 2'd0);
    assign do_enq     = enq & ~full;
    assign do_deq     = deq & head_valid;
    assign head_data  = head_valid ? mem[head] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (do_enq) begin
                tail <= ~tail;
            end
            if (do_deq) begin
                head <= ~head;
            end
            count <= count + 2'(do_enq) - 2'(do_deq);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[tail] <= enq_data;
        end
    end

endmodule

// File: rtl/steer_merge.sv
// rtl/steer_merge.sv - merges left/right token streams in select-token order
module steer_merge
    import steer_merge_pkg::*;
#(
    parameter int W = GO_LENGTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W:0]   left_path,
    output logic         left_path_back_stop,
    input  logic [W:0]   right_path,
    output logic         right_path_back_stop,
    input  logic [1:0]   go_right,
    output logic         go_right_back_stop,
    output logic [W:0]   out_data,
    input  logic         back_stop
);

    logic         sel_v;
    path_e        sel;
    logic         chosen_v;
    logic [W-1:0] chosen_payload;
    logic         full;
    logic         fire;
    logic         deq;
    logic         head_valid;
    logic [W-1:0] head_data;

    assign sel_v          = go_right[1];
    assign sel            = path_e'(go_right[0]);
    assign chosen_v       = (sel == PATH_RIGHT) ? tok_valid(right_path) : tok_valid(left_path);
    assign chosen_payload = (sel == PATH_RIGHT) ? tok_payload(right_path) : tok_payload(left_path);

    // Entry is blocked on full even if the head leaves this cycle, so the
    // stops never depend combinationally on back_stop.
    assign fire = rst_n & sel_v & chosen_v & ~full;
    assign deq  = head_valid & ~back_stop;

    assign go_right_back_stop   = ~fire;
    assign right_path_back_stop = ~(fire & (sel == PATH_RIGHT));
    assign left_path_back_stop  = ~(fire & (sel == PATH_LEFT));
    assign out_data             = {head_valid, head_data};

    elastic_buf2 #(
        .W(W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .enq        (fire),
        .enq_data   (chosen_payload),
        .deq        (deq),
        .full       (full),
        .head_valid (head_valid),
        .head_data  (head_data)
    );

endmodule

// File: tb/tb_steer_merge.sv
// tb/tb_steer_merge.sv - table vectors plus randomized reference-model checks for steer_merge
module tb_steer_merge;

    logic       clk;
    logic       rst_n;
    logic [8:0] left_path;
    logic       left_path_back_stop;
    logic [8:0] right_path;
    logic       right_path_back_stop;
    logic [1:0] go_right;
    logic       go_right_back_stop;
    logic [8:0] out_data;
    logic       back_stop;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [1:0] go;
        logic [8:0] l;
        logic [8:0] r;
        logic       bs;
        logic       gs;
        logic       ls;
        logic       rs;
        logic [8:0] od;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] model_q[$];

    steer_merge #(.W(8)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .left_path            (left_path),
        .left_path_back_stop  (left_path_back_stop),
        .right_path           (right_path),
        .right_path_back_stop (right_path_back_stop),
        .go_right             (go_right),
        .go_right_back_stop   (go_right_back_stop),
        .out_data             (out_data),
        .back_stop            (back_stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic rst, logic [1:0] go, logic [8:0] l, logic [8:0] r,
                                logic bs, logic gs, logic ls, logic rs, logic [8:0] od);
        vec_t v;
        v.rst = rst; v.go = go; v.l = l; v.r = r; v.bs = bs;
        v.gs = gs; v.ls = ls; v.rs = rs; v.od = od;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // One clock: drive, check mid-cycle, then advance the queue model past the edge.
    task automatic run_cycle(input vec_t v_in, input bit use_model, input int idx, output bit fired);
        vec_t v;
        bit   fire;
        v = v_in;
        rst_n = v.rst; go_right = v.go; left_path = v.l; right_path = v.r; back_stop = v.bs;
        fire = v.rst && v.go[1] && (v.go[0] ? v.r[8] : v.l[8]) && (model_q.size() < 2);
        if (use_model) begin
            v.gs = !fire;
            v.rs = !(fire && v.go[0]);
            v.ls = !(fire && !v.go[0]);
            v.od = (model_q.size() != 0) ? {1'b1, model_q[0]} : 9'h000;
        end
        #4;
        check("go_stop",    idx, 9'(go_right_back_stop),   9'(v.gs));
        check("left_stop",  idx, 9'(left_path_back_stop),  9'(v.ls));
        check("right_stop", idx, 9'(right_path_back_stop), 9'(v.rs));
        check("out_data",   idx, out_data, v.od);
        @(posedge clk);
        if (!v.rst) begin
            model_q.delete();
        end else begin
            if (model_q.size() != 0 && !v.bs) void'(model_q.pop_front());
            if (fire) model_q.push_back(v.go[0] ? v.r[7:0] : v.l[7:0]);
        end
        fired = fire;
        #1;
    endtask

    initial begin
        bit         fired;
        vec_t       v;
        logic [1:0] go;
        logic [8:0] l;
        logic [8:0] r;

        rst_n = 1'b0; go_right = 2'b00; left_path = '0; right_path = '0; back_stop = 1'b0;
        @(posedge clk);
        #1;

        // reset state
        tbl.push_back(mk(0, 2'b11, 9'h1FF, 9'h1FF, 0, 1, 1, 1, 9'h000));
        // basic alternation
        tbl.push_back(mk(1, 2'b10, 9'h111, 9'h122, 0, 0, 0, 1, 9'h000));
        tbl.push_back(mk(1, 2'b11, 9'h133, 9'h122, 0, 0, 1, 0, 9'h111));
        tbl.push_back(mk(1, 2'b10, 9'h133, 9'h122, 0, 0, 0, 1, 9'h122));
        tbl.push_back(mk(1, 2'b00, 9'h000, 9'h000, 0, 1, 1, 1, 9'h133));
        // missing data on the selected path
        tbl.push_back(mk(1, 2'b11, 9'h000, 9'h000, 0, 1, 1, 1, 9'h000));
        tbl.push_back(mk(1, 2'b11, 9'h000, 9'h0A5, 0, 1, 1, 1, 9'h000));
        tbl.push_back(mk(1, 2'b11, 9'h000, 9'h000, 0, 1, 1, 1, 9'h000));
        tbl.push_back(mk(1, 2'b11, 9'h000, 9'h1A5, 0, 0, 1, 0, 9'h000));
        tbl.push_back(mk(1, 2'b00, 9'h000, 9'h000, 0, 1, 1, 1, 9'h1A5));
        // backpressure until full, then release
        tbl.push_back(mk(1, 2'b10, 9'h101, 9'h000, 1, 0, 0, 1, 9'h000));
        tbl.push_back(mk(1, 2'b10, 9'h102, 9'h000, 1, 0, 0, 1, 9'h101));
        tbl.push_back(mk(1, 2'b10, 9'h103, 9'h000, 1, 1, 1, 1, 9'h101));
        tbl.push_back(mk(1, 2'b10, 9'h103, 9'h000, 1, 1, 1, 1, 9'h101));
        tbl.push_back(mk(1, 2'b10, 9'h103, 9'h000, 0, 1, 1, 1, 9'h101));
        // count held at 1 with enq and deq each cycle
        tbl.push_back(mk(1, 2'b10, 9'h103, 9'h000, 0, 0, 0, 1, 9'h102));
        tbl.push_back(mk(1, 2'b10, 9'h104, 9'h000, 0, 0, 0, 1, 9'h103));
        tbl.push_back(mk(1, 2'b10, 9'h105, 9'h000, 0, 0, 0, 1, 9'h104));
        tbl.push_back(mk(1, 2'b00, 9'h000, 9'h000, 0, 1, 1, 1, 9'h105));
        // no select token, both paths valid
        tbl.push_back(mk(1, 2'b00, 9'h1AA, 9'h1BB, 0, 1, 1, 1, 9'h000));
        tbl.push_back(mk(1, 2'b00, 9'h1AA, 9'h1BB, 0, 1, 1, 1, 9'h000));
        // reset with two tokens buffered, held token accepted afterwards
        tbl.push_back(mk(1, 2'b10, 9'h1C1, 9'h000, 1, 0, 0, 1, 9'h000));
        tbl.push_back(mk(1, 2'b11, 9'h000, 9'h1C2, 1, 0, 1, 0, 9'h1C1));
        tbl.push_back(mk(0, 2'b10, 9'h1C3, 9'h000, 1, 1, 1, 1, 9'h1C1));
        tbl.push_back(mk(1, 2'b10, 9'h1C3, 9'h000, 1, 0, 0, 1, 9'h000));
        tbl.push_back(mk(1, 2'b00, 9'h000, 9'h000, 0, 1, 1, 1, 9'h1C3));
        tbl.push_back(mk(1, 2'b00, 9'h000, 9'h000, 0, 1, 1, 1, 9'h000));

        for (int i = 0; i < tbl.size(); i++) begin
            run_cycle(tbl[i], 1'b0, i, fired);
        end

        // randomized traffic; producers hold tokens until the model says they were taken
        go = 2'(($urandom & 32'h3)); l = 9'($urandom); r = 9'($urandom);
        for (int i = 0; i < 600; i++) begin
            v = mk(($urandom_range(0, 49) != 0), go, l, r, ($urandom_range(0, 2) == 0),
                   1'b0, 1'b0, 1'b0, 9'h000);
            run_cycle(v, 1'b1, 1000 + i, fired);
            if (!go[1] || fired) go = 2'($urandom & 32'h3);
            if (!l[8] || (fired && !v.go[0])) l = 9'($urandom);
            if (!r[8] || (fired && v.go[0])) r = 9'($urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
